// File: rtl/sub_bytes_iter.sv
`default_nettype none
// ============================================================================
// Module   : sub_bytes_iter
// Purpose  : Iterative AES SubBytes / InvSubBytes engine. A state of NBYTES
//            bytes is captured on Start and substituted LANES bytes per
//            clock. The finished state is held on Data_out until the next
//            completion.
// Ports    : CLK      - rising-edge clock
//            RST_N    - asynchronous active-low reset
//            Start    - operation request, sampled only while idle
//            Inverse  - 0 = forward S-box, 1 = inverse S-box (captured)
//            Data_in  - input state, byte i at bits [8i+7:8i] (captured)
//            Busy     - high while an operation is in progress
//            Done     - one-cycle pulse when Data_out has just been updated
//            Data_out - last completed result
// Revision : 1.0 - initial release
// ============================================================================
module sub_bytes_iter #(
  parameter int NBYTES = 16,
  parameter int LANES  = 4
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                Start,
  input  logic                Inverse,
  input  logic [8*NBYTES-1:0] Data_in,
  output logic                Busy,
  output logic                Done,
  output logic [8*NBYTES-1:0] Data_out
);

  localparam int BEATS = NBYTES / LANES;
  // Counter is at least one bit wide so BEATS = 1 still elaborates.
  localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] c_last_beat = CW'(BEATS - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  state_t              r_state;
  logic [CW-1:0]       r_cnt;
  logic                r_inv;
  logic [8*NBYTES-1:0] r_work;
  logic [8*NBYTES-1:0] w_work_next;
  logic [7:0]          w_lane_in  [LANES];
  logic [7:0]          w_lane_out [LANES];

  // --------------------------------------------------------------------------
  // GF(2^8) arithmetic, reduction polynomial x^8 + x^4 + x^3 + x + 1.
  // --------------------------------------------------------------------------
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (a^255 = 1 for a != 0), which also maps
  // 0 to 0 as the S-box requires. 254 = 2+4+...+128, so the result is the
  // product of seven successive squarings.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = gf_mul(a, a);
    acc = sq;
    for (int i = 0; i < 6; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  // Forward affine map: b ^ rotl1 ^ rotl2 ^ rotl3 ^ rotl4 ^ 0x63.
  function automatic logic [7:0] affine_fwd(input logic [7:0] b);
    return b
         ^ {b[6:0], b[7]}
         ^ {b[5:0], b[7:6]}
         ^ {b[4:0], b[7:5]}
         ^ {b[3:0], b[7:4]}
         ^ 8'h63;
  endfunction

  // Inverse affine map: rotl1 ^ rotl3 ^ rotl6 ^ 0x05.
  function automatic logic [7:0] affine_inv(input logic [7:0] s);
    return {s[6:0], s[7]}
         ^ {s[4:0], s[7:5]}
         ^ {s[1:0], s[7:2]}
         ^ 8'h05;
  endfunction

  function automatic logic [7:0] sbox_fwd(input logic [7:0] a);
    return affine_fwd(gf_inv(a));
  endfunction

  function automatic logic [7:0] sbox_inv(input logic [7:0] a);
    return gf_inv(affine_inv(a));
  endfunction

  // --------------------------------------------------------------------------
  // S-box lanes: lane l works on byte LANES*cnt + l of the working register.
  // --------------------------------------------------------------------------
  generate
    for (genvar l = 0; l < LANES; l++) begin : g_lane
      assign w_lane_in[l]  = r_work[(int'(r_cnt) * LANES + l) * 8 +: 8];
      assign w_lane_out[l] = r_inv ? sbox_inv(w_lane_in[l]) : sbox_fwd(w_lane_in[l]);
    end
  endgenerate

  // Working register with the current beat's bytes replaced. On the final
  // beat this is the complete result, so it feeds Data_out directly.
  always_comb begin
    w_work_next = r_work;
    for (int l = 0; l < LANES; l++) begin
      w_work_next[(int'(r_cnt) * LANES + l) * 8 +: 8] = w_lane_out[l];
    end
  end

  // --------------------------------------------------------------------------
  // Control FSM with registered outputs.
  // --------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_inv    <= 1'b0;
      r_work   <= '0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      Data_out <= '0;
    end else begin
      Done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            r_work  <= Data_in;
            r_inv   <= Inverse;
            r_cnt   <= '0;
            Busy    <= 1'b1;
            r_state <= S_BUSY;
          end
        end
        S_BUSY: begin
          r_work <= w_work_next;
          if (r_cnt == c_last_beat) begin
            Data_out <= w_work_next;
            Done     <= 1'b1;
            Busy     <= 1'b0;
            // Parking the counter at 0 keeps the lane indices in range while
            // idle even when BEATS is not a power of two.
            r_cnt    <= '0;
            r_state  <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/sub_bytes_iter.md
# sub_bytes_iter

Parametrised, iterative AES SubBytes / InvSubBytes engine for the AES-128 datapath. It takes a start-qualified state of NBYTES bytes and substitutes LANES bytes per clock, so area and throughput can be traded without changing the interface. The result is held on Data_out until the next completion. It sits between AddRoundKey and ShiftRows in the round datapath, and in the inverse path between InvShiftRows and AddRoundKey.

## Interface
- NBYTES, default 16: bytes per state. Data width is 8*NBYTES.
- LANES, default 4: S-box instances, i.e. bytes substituted per beat. Must divide NBYTES.
- BEATS (localparam) = NBYTES/LANES.
- CLK  input  1  rising-edge clock, the only clock.
- RST_N  input  1  asynchronous, active-low reset.
- Start  input  1  request. Sampled only while idle.
- Inverse  input  1  0 = forward S-box, 1 = inverse S-box. Captured with Start.
- Data_in  input  8*NBYTES  input state. Byte i = bits [8i+7:8i]. Captured with Start.
- Busy  output  1  high while an operation is in progress.
- Done  output  1  one-cycle pulse when Data_out has just been updated.
- Data_out  output  8*NBYTES  last completed result.

## Operation
- S-box and inverse S-box follow FIPS-197 exactly. Table or GF(2^8)-inverse+affine implementation are both acceptable. Both must be selectable per operation.
- FSM has two states: IDLE and BUSY.
- IDLE:
  - Start=1 at an edge: capture Data_in and Inverse into a working register, clear beat counter, go to BUSY.
  - Start=0: stay in IDLE.
- BUSY:
  - Each edge substitutes bytes [LANES*cnt .. LANES*cnt+LANES-1] of the working register in place, then increments cnt.
  - On the edge where cnt = BEATS-1, the fully substituted state is written to Data_out, Done is set to 1, and the FSM returns to IDLE.
- Start while BUSY is ignored. It is neither queued nor error-flagged.
- Data_in and Inverse changes after capture have no effect on the running operation.
- Data_out changes only on completion, never mid-operation.
- Beat counter width is clog2(BEATS), minimum 1 bit. It is cleared on every accepted Start.
- LANES = NBYTES is legal: BEATS = 1, and each operation is a single beat.

## Timing
- Reset (RST_N=0, asynchronous) drives every output to 0: Busy=0, Done=0, Data_out=0. FSM goes to IDLE and the counter to 0. The working register contents are don't-care.
- Reset during BUSY aborts the operation. No Done is produced and Data_out reads 0.
- Start sampled at edge k produces:
  - Busy=1 from edge k to edge k+BEATS, i.e. BEATS cycles.
  - Data_out valid and Done=1 from edge k+BEATS for exactly one cycle.
- Latency from Start edge to Done is BEATS cycles.
- During the Done cycle the FSM is IDLE, so a Start held high is accepted at edge k+BEATS+1.
- Maximum throughput is one state per BEATS+1 cycles.
- Done is never asserted two cycles in a row.
- Start exactly at the completion edge k+BEATS is ignored, because the FSM is still BUSY when it is sampled.

## Test plan
- Defaults (16/4), Inverse=0. Data_in=128'h11111111111111111111111111111111, Start for 1 cycle.
  - Busy high for 4 cycles.
  - Done pulse 4 cycles after the Start edge.
  - Data_out=128'h82828282828282828282828282828282.
- Defaults, forward. Data_in=128'h00112233445566778899aabbccddeeff.
  - Data_out=128'h638293c31bfc33f5c4eeacea4bc12816.
  - Repeat with Inverse=1 and that result as input: Data_out returns 128'h00112233445566778899aabbccddeeff.
- Back-to-back with Start held high. Inputs 128'h22…22, then 128'h00…00.
  - First Done gives 128'h93…93.
  - Second operation is accepted at edge k+5.
  - Second Done at k+9 gives 128'h63…63.
  - Start pulses mid-BUSY are ignored and produce no extra Done.
- Capture isolation. Change Data_in and Inverse every cycle while BUSY.
  - Result matches only the values captured at Start.
  - Data_out stays constant until Done.
- Reset mid-operation. Assert RST_N=0 at beat 2 of 4.
  - Busy, Done and Data_out go to 0 immediately, asynchronously.
  - No Done appears after release.
  - A new Start then completes normally.
- Parameter sweep over LANES=1, 16 and over NBYTES=4 with LANES=2.
  - Latency equals BEATS (16, 1 and 2 respectively).
  - Byte 0x53 maps to 0xED forward and 0x63 maps to 0x00 inverse in every lane.
